scan_counter_display: RTL and testbench

Parametrised multi-digit up/down counter with integrated prescaler and time-multiplexed seven-segment driver. Generalises the single-digit counter/divider/decoder chain to DIGITS digits, decimal or hex counting, parallel load, wrap/borrow flag, and anode scanning for a common-anode multi-digit display. Sits at the top of the display path, driven directly by the board clock.

---
 rtl/scan_counter_display.sv | 171 +++++++++++++++++
 tb/tb_scan_counter_display.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_counter_display.sv
// -----------------------------------------------------------------------------
// scan_counter_display
//
// Multi-digit up/down counter (BCD or hex digits) with a free-running prescaler
// and a time-multiplexed seven-segment driver for a common-anode display.
//
// Parameters
//   DIGITS     number of 4-bit digits counted and scanned (1..8)
//   HEX_MODE   0 = digits wrap 9<->0, 1 = digits wrap F<->0
//   DIV_COUNT  clock cycles per count tick (>= 2)
//   SCAN_COUNT clock cycles per digit scan step (>= 2)
//
// Ports
//   Clk_In    system clock, rising edge
//   Rst       synchronous active-high reset
//   Enable    1 = count on tick, 0 = hold (prescaler keeps running)
//   UpDown    1 = count up, 0 = count down
//   Load      parallel load strobe (wins over a coincident tick)
//   Load_Val  load value, digit i in bits [4i+3:4i]
//   Count     current counter value, same packing
//   Carry     one-cycle pulse after the counter wraps in either direction
//   Seg       active-low {A,B,C,D,E,F,G} of the selected digit (registered)
//   Anode     active-low one-hot digit select (registered)
// -----------------------------------------------------------------------------
module scan_counter_display #(
   parameter int DIGITS     = 4,
   parameter bit HEX_MODE   = 1'b0,
   parameter int DIV_COUNT  = 50000000,
   parameter int SCAN_COUNT = 100000
) (
   input  logic                  Clk_In,
   input  logic                  Rst,
   input  logic                  Enable,
   input  logic                  UpDown,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   Load_Val,
   output logic [4*DIGITS-1:0]   Count,
   output logic                  Carry,
   output logic [6:0]            Seg,
   output logic [DIGITS-1:0]     Anode
);

   localparam int DW = $clog2(DIV_COUNT);
   localparam int SW = $clog2(SCAN_COUNT);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_COUNT - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [3:0]    DIGIT_MAX = HEX_MODE ? 4'hF : 4'h9;

   logic [DW-1:0]          div_cnt;
   logic [SW-1:0]          scan_cnt;
   logic [IW-1:0]          idx;
   logic                   tick;
   logic                   scan_step;
   logic [4*DIGITS-1:0]    step_val;
   logic [4*DIGITS-1:0]    load_fix;
   logic                   wrap;
   logic                   ripple;
   logic [3:0]             cur_digit;
   logic [6:0]             glyph;

   assign tick      = (div_cnt == DIV_LAST);
   assign scan_step = (scan_cnt == SCAN_LAST);

   // Ripple counter step: each digit moves only while every lower digit is
   // rolling over; if the ripple survives past the top digit, the whole
   // counter has wrapped.
   // NOTE: every variable gets a default before any conditional assignment,
   // so no path through the block leaves a value unassigned (no latch).
   always_comb begin
      step_val = Count;
      ripple   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (ripple) begin
            if (UpDown) begin
               if (Count[4*i +: 4] == DIGIT_MAX) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = Count[4*i +: 4] + 4'd1;
                  ripple             = 1'b0;
               end
            end else begin
               if (Count[4*i +: 4] == 4'd0) begin
                  step_val[4*i +: 4] = DIGIT_MAX;
               end else begin
                  step_val[4*i +: 4] = Count[4*i +: 4] - 4'd1;
                  ripple             = 1'b0;
               end
            end
         end
      end
      wrap = ripple;
   end

   // In BCD mode an out-of-range loaded digit saturates at 9.
   always_comb begin
      load_fix = Load_Val;
      for (int i = 0; i < DIGITS; i++) begin
         if (!HEX_MODE && (Load_Val[4*i +: 4] > 4'd9)) begin
            load_fix[4*i +: 4] = 4'd9;
         end
      end
   end

   // Digit currently being scanned.
   always_comb begin
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_digit = Count[4*i +: 4];
         end
      end
   end

   // Active-low {A,B,C,D,E,F,G} glyphs, full hex set in both modes.
   always_comb begin
      case (cur_digit)
         4'h0:    glyph = 7'b0000001;
         4'h1:    glyph = 7'b1001111;
         4'h2:    glyph = 7'b0010010;
         4'h3:    glyph = 7'b0000110;
         4'h4:    glyph = 7'b1001100;
         4'h5:    glyph = 7'b0100100;
         4'h6:    glyph = 7'b0100000;
         4'h7:    glyph = 7'b0001111;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0000100;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b1100000;
         4'hC:    glyph = 7'b0110001;
         4'hD:    glyph = 7'b1000010;
         4'hE:    glyph = 7'b0110000;
         default: glyph = 7'b0111000;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clk_In) begin
      if (Rst) begin
         div_cnt  <= '0;
         scan_cnt <= '0;
         idx      <= '0;
         Count    <= '0;
         Carry    <= 1'b0;
         Seg      <= 7'b1111111;
         Anode    <= '1;
      end else begin
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         scan_cnt <= scan_step ? '0 : scan_cnt + 1'b1;
         if (scan_step) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end

         // Display path lags the index/count by one cycle.
         Seg   <= glyph;
         Anode <= ~(DIGITS'(1) << idx);

         Carry <= 1'b0;
         if (Load) begin
            Count <= load_fix;           // a coincident tick is dropped
         end else if (tick && Enable) begin
            Count <= step_val;
            Carry <= wrap;
         end
      end
   end

endmodule

// File: tb/tb_scan_counter_display.sv
// -----------------------------------------------------------------------------
// tb_scan_counter_display
//
// Drives three configurations of scan_counter_display from shared stimulus and
// compares them every cycle against an integer-valued reference model; adds a
// directed vector table and hand-written scan / reset sequences.
// -----------------------------------------------------------------------------
module tb_scan_counter_display;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, ud, ld;
   logic [15:0] lv;

   logic [15:0] b_count;  logic b_carry;  logic [6:0] b_seg;  logic [3:0] b_an;
   logic [7:0]  h_count;  logic h_carry;  logic [6:0] h_seg;  logic [1:0] h_an;
   logic [3:0]  o_count;  logic o_carry;  logic [6:0] o_seg;  logic [0:0] o_an;

   scan_counter_display #(.DIGITS(4), .HEX_MODE(1'b0), .DIV_COUNT(4), .SCAN_COUNT(3)) u_bcd (
      .Clk_In(clk), .Rst(rst), .Enable(en), .UpDown(ud), .Load(ld), .Load_Val(lv),
      .Count(b_count), .Carry(b_carry), .Seg(b_seg), .Anode(b_an));

   scan_counter_display #(.DIGITS(2), .HEX_MODE(1'b1), .DIV_COUNT(4), .SCAN_COUNT(3)) u_hex (
      .Clk_In(clk), .Rst(rst), .Enable(en), .UpDown(ud), .Load(ld), .Load_Val(lv[7:0]),
      .Count(h_count), .Carry(h_carry), .Seg(h_seg), .Anode(h_an));

   scan_counter_display #(.DIGITS(1), .HEX_MODE(1'b1), .DIV_COUNT(3), .SCAN_COUNT(2)) u_one (
      .Clk_In(clk), .Rst(rst), .Enable(en), .UpDown(ud), .Load(ld), .Load_Val(lv[3:0]),
      .Count(o_count), .Carry(o_carry), .Seg(o_seg), .Anode(o_an));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [6:0] glyphs [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: the count is a plain integer modulo base**digits.
   typedef struct {
      int digits; int base; int div; int scan;
      int value; int carry; int pre; int spre; int idx; int seg; int an;
   } mdl_t;

   mdl_t mb, mh, mo;

   function automatic int ipow(input int b, input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r *= b;
      return r;
   endfunction

   function automatic int digit_of(input mdl_t m, input int i);
      return (m.value / ipow(m.base, i)) % m.base;
   endfunction

   function automatic logic [31:0] pack(input mdl_t m);
      logic [31:0] r = '0;
      for (int i = 0; i < m.digits; i++) r |= 32'(digit_of(m, i)) << (4*i);
      return r;
   endfunction

   function automatic mdl_t mk(input int d, input int b, input int dv, input int s);
      mdl_t m;
      m.digits = d; m.base = b; m.div = dv; m.scan = s;
      m.value = 0; m.carry = 0; m.pre = 0; m.spre = 0; m.idx = 0;
      m.seg = 7'h7F; m.an = (1 << d) - 1;
      return m;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit r, input bit e, input bit u,
                                  input bit l, input logic [15:0] v);
      mdl_t n    = m;
      int   full = ipow(m.base, m.digits);
      int   mask = (1 << m.digits) - 1;
      bit   tick = (m.pre == m.div - 1);
      if (r) begin
         n.value = 0; n.carry = 0; n.pre = 0; n.spre = 0; n.idx = 0;
         n.seg = 7'h7F; n.an = mask;
         return n;
      end
      n.seg  = glyphs[digit_of(m, m.idx)];
      n.an   = mask & ~(1 << m.idx);
      n.pre  = (m.pre + 1) % m.div;
      n.spre = (m.spre + 1) % m.scan;
      if (m.spre == m.scan - 1) n.idx = (m.idx + 1) % m.digits;
      n.carry = 0;
      if (l) begin
         n.value = 0;
         for (int i = 0; i < m.digits; i++) begin
            int d = int'((v >> (4*i)) & 16'hF);
            if (m.base == 10 && d > 9) d = 9;
            n.value += d * ipow(m.base, i);
         end
      end else if (tick && e) begin
         if (u) begin
            if (m.value == full - 1) begin n.value = 0; n.carry = 1; end
            else n.value = m.value + 1;
         end else begin
            if (m.value == 0) begin n.value = full - 1; n.carry = 1; end
            else n.value = m.value - 1;
         end
      end
      return n;
   endfunction

   task automatic drive(input bit r, input bit e, input bit u, input bit l, input logic [15:0] v);
      rst = r; en = e; ud = u; ld = l; lv = v;
   endtask

   // One clock: step the models on the edge, then compare all instances.
   task automatic cycle();
      @(posedge clk);
      mb = mstep(mb, rst, en, ud, ld, lv);
      mh = mstep(mh, rst, en, ud, ld, {8'h00, lv[7:0]});
      mo = mstep(mo, rst, en, ud, ld, {12'h000, lv[3:0]});
      #1;
      check("bcd_count", 32'(b_count), pack(mb));
      check("bcd_carry", 32'(b_carry), mb.carry);
      check("bcd_seg",   32'(b_seg),   mb.seg);
      check("bcd_anode", 32'(b_an),    mb.an);
      check("hex_count", 32'(h_count), pack(mh));
      check("hex_carry", 32'(h_carry), mh.carry);
      check("hex_seg",   32'(h_seg),   mh.seg);
      check("hex_anode", 32'(h_an),    mh.an);
      check("one_count", 32'(o_count), pack(mo));
      check("one_carry", 32'(o_carry), mo.carry);
      check("one_seg",   32'(o_seg),   mo.seg);
      check("one_anode", 32'(o_an),    mo.an);
   endtask

   typedef struct {
      bit r, e, u, l;
      logic [15:0] v;
      logic [15:0] bc; bit bcy;
      logic [7:0]  hc; bit hcy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input bit r, input bit e, input bit u, input bit l,
                      input logic [15:0] v, input logic [15:0] bc, input bit bcy,
                      input logic [7:0] hc, input bit hcy);
      vec_t t;
      t.r = r; t.e = e; t.u = u; t.l = l; t.v = v;
      t.bc = bc; t.bcy = bcy; t.hc = hc; t.hcy = hcy;
      repeat (n) vecs.push_back(t);
   endtask

   initial begin
      mb = mk(4, 10, 4, 3);
      mh = mk(2, 16, 4, 3);
      mo = mk(1, 16, 3, 2);
      drive(1, 0, 0, 0, 16'h0000);

      // Directed table: ticks land on rows 4, 8, 12, ... after the reset row.
      //   n  r  e  u  l  load      bcd    cy  hex    cy
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
      add(3, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
      add(1, 0, 1, 0, 0, 16'h0000, 16'h9999, 1, 8'hFF, 1);  // down wrap from 0
      add(3, 0, 1, 0, 0, 16'h0000, 16'h9999, 0, 8'hFF, 0);
      add(1, 0, 1, 0, 0, 16'h0000, 16'h9998, 0, 8'hFE, 0);
      add(1, 0, 1, 1, 1, 16'h5A5A, 16'h5959, 0, 8'h5A, 0);  // BCD clamp on load
      add(2, 0, 1, 1, 0, 16'h0000, 16'h5959, 0, 8'h5A, 0);
      add(1, 0, 1, 1, 0, 16'h0000, 16'h5960, 0, 8'h5B, 0);
      add(1, 0, 1, 1, 1, 16'h99FE, 16'h9999, 0, 8'hFE, 0);
      add(2, 0, 1, 1, 0, 16'h0000, 16'h9999, 0, 8'hFE, 0);
      add(1, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 8'hFF, 0);  // up wrap at max
      add(3, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 8'hFF, 0);
      add(1, 0, 1, 1, 0, 16'h0000, 16'h0001, 0, 8'h00, 1);
      add(3, 0, 1, 1, 0, 16'h0000, 16'h0001, 0, 8'h00, 0);
      add(1, 0, 1, 1, 1, 16'h0042, 16'h0042, 0, 8'h42, 0);  // load beats tick
      add(3, 0, 1, 1, 0, 16'h0000, 16'h0042, 0, 8'h42, 0);
      add(1, 0, 1, 1, 0, 16'h0000, 16'h0043, 0, 8'h43, 0);
      add(4, 0, 0, 1, 0, 16'h0000, 16'h0043, 0, 8'h43, 0);  // disabled tick held
      add(1, 0, 1, 0, 1, 16'h0090, 16'h0090, 0, 8'h90, 0);
      add(2, 0, 1, 0, 0, 16'h0000, 16'h0090, 0, 8'h90, 0);
      add(1, 0, 1, 0, 0, 16'h0000, 16'h0089, 0, 8'h8F, 0);  // 90->89 no carry

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].e, vecs[k].u, vecs[k].l, vecs[k].v);
         cycle();
         check($sformatf("tbl%0d_bcd", k),    32'(b_count), 32'(vecs[k].bc));
         check($sformatf("tbl%0d_bcd_cy", k), 32'(b_carry), 32'(vecs[k].bcy));
         check($sformatf("tbl%0d_hex", k),    32'(h_count), 32'(vecs[k].hc));
         check($sformatf("tbl%0d_hex_cy", k), 32'(h_carry), 32'(vecs[k].hcy));
      end

      // Scan sequence: 0x1590 held, index advances every 3 cycles.
      drive(1, 0, 0, 0, 16'h0000);
      cycle();
      check("scan_rst_anode", 32'(b_an),  32'h0000000F);
      check("scan_rst_seg",   32'(b_seg), 32'h0000007F);
      drive(0, 0, 0, 1, 16'h1590);
      for (int k = 1; k <= 13; k++) begin
         int          sidx;
         logic [15:0] shown;
         cycle();
         sidx  = ((k - 1) / 3) % 4;
         shown = 16'h1590 >> (4*sidx);
         check($sformatf("scan%0d_anode", k), 32'(b_an),  32'(4'hF & ~(4'h1 << sidx)));
         check($sformatf("scan%0d_seg", k),   32'(b_seg), 32'(glyphs[shown[3:0]]));
         drive(0, 0, 0, 0, 16'h0000);
      end
      check("scan_count_held", 32'(b_count), 32'h00001590);

      // Reset mid-count, coincident with a load.
      drive(0, 1, 1, 0, 16'h0000);
      repeat (6) cycle();
      drive(1, 1, 1, 1, 16'h1234);
      cycle();
      check("mid_rst_count", 32'(b_count), 32'h0);
      check("mid_rst_carry", 32'(b_carry), 32'h0);
      check("mid_rst_anode", 32'(b_an),    32'hF);
      check("mid_rst_seg",   32'(b_seg),   32'h7F);
      drive(0, 1, 1, 0, 16'h0000);
      for (int k = 1; k <= 4; k++) begin
         cycle();
         check($sformatf("resume%0d_count", k), 32'(b_count), (k == 4) ? 32'h1 : 32'h0);
         if (k == 1) check("one_digit_anode", 32'(o_an), 32'h0);
      end

      // Randomized stimulus against the model.
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 16'($urandom));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
